uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Runtime-configurable UART receiver; successor to the fixed 8N1 receiver.
- Adds 5..DATA_W data bits, none/even/odd parity, and 1 or 2 stop bits.
- Adds 3-sample majority voting, false-start rejection, and parity/framing error flags.
- Sits between the board RX pin and the loopback/command logic; the divisor comes from the same per-bit count input as before.

Parameters:
- DATA_W, 8, maximum data bits per frame (legal 5..9); width of uart_data.
- CNT_W, 16, width of the bit-period counter and of uart_cnt.
- SYNC_STAGES, 2, flops in the uart_rxd input synchroniser (legal >=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_cnt  in  CNT_W  clocks per bit, minus nothing (100 = 100 clk per bit); legal >=8.
- cfg_data_bits  in  4  data bits per frame, 5..DATA_W.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- uart_rxd  in  1  serial line; idles high.
- uart_data  out  DATA_W  received word, LSB-aligned, unused upper bits 0.
- uart_done  out  1  one-cycle pulse: frame complete, outputs valid.
- uart_busy  out  1  frame in progress.
- uart_perr  out  1  parity mismatch on the last frame.
- uart_ferr  out  1  a stop bit sampled low on the last frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - uart_data, uart_done, uart_busy, uart_perr and uart_ferr all reset to 0.
  - Synchroniser flops and the edge-detect register reset to 1.
  - FSM resets to IDLE. Reset mid-frame aborts the frame with no done pulse.
- Synchronisation: uart_rxd passes through SYNC_STAGES flops. All logic uses the synchronised signal rxs.
- Start detect:
  - In IDLE, a registered-previous rxs=1 followed by current rxs=0 triggers the start.
  - The pin-to-detect delay is SYNC_STAGES+1 cycles.
  - A line held low never retriggers; a new start needs rxs seen high first.
- Config capture: on start detect, latch uart_cnt, cfg_data_bits, cfg_parity and cfg_stop2. Changes mid-frame have no effect.
- Bit timing:
  - The bit counter runs 0..cnt-1 and is restarted on start detect.
  - half = cnt>>1.
  - Each bit takes 3 samples, at counter values half-1, half and half+1. The bit value is the majority of the three.
  - The decision is made at half+1.
- FSM:
  - IDLE -> START on detect.
  - START: if the majority value is 1, it is a false start. Return to IDLE, drop busy, no done, outputs unchanged. Otherwise go to DATA at bit end.
  - DATA: receive cfg_data_bits bits, LSB first, into a shift register. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: sample one bit.
    - Even: perr = XOR(data bits, parity bit) != 0.
    - Odd: perr = XOR(data bits, parity bit) != 1.
  - STOP: sample the stop bit; a 0 sets the ferr candidate.
    - If cfg_stop2, wait one full bit and sample the second stop bit too; either low sets ferr.
    - At the decision point of the final stop bit, go to IDLE.
- Completion, in the cycle the final stop bit is decided:
  - uart_done=1 for exactly one cycle.
  - uart_data, uart_perr and uart_ferr update in that same cycle and hold until the next done.
  - uart_perr=0 when parity is none.
- Error frames: done pulses even when ferr or perr is set. Data is still delivered.
- uart_busy:
  - Goes to 1 in the cycle after start detect and stays 1 through the done cycle; 0 in the following cycle.
  - On a false start, busy goes to 0 in the cycle after the START decision.
- Early restart: the FSM is in IDLE about half a bit before the line's stop-bit end, so back-to-back frames are received.
- Width rules:
  - The data shift register is DATA_W wide.
  - Bits at and above cfg_data_bits are forced to 0 at done.
  - cfg_data_bits outside 5..DATA_W is clamped to DATA_W.

Test Plan:
1. uart_cnt=100, 8N1, send 0xA5 -> one done pulse; uart_data=0xA5, perr=0, ferr=0; busy high for about 950 cycles.
2. 7 data bits, even parity, send 0x41 with parity bit 1 (wrong) -> done; uart_data=0x41, perr=1. Resend with parity 0 -> perr=0.
3. 5 data bits, odd parity, 2 stop bits, second stop bit low, data 0x15 -> done only after the second stop bit; uart_data=0x15, ferr=1. Hold the line low for 2000 cycles -> no further busy or done.
4. 30-cycle low glitch on an idle line (uart_cnt=100) -> busy pulses, no done, uart_data unchanged.
5. 8N1 0x3C with a 1-cycle inverted glitch at the centre of bit 2 -> uart_data=0x3C (majority rejects the glitch).
6. rst_n low mid-DATA of 0xFF -> all outputs 0. A following clean 0x5A frame after reset release -> uart_data=0x5A, no stale bits.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, frame config and received-frame outputs of the configurable UART receiver
// master: drives uart_cnt, cfg_* and uart_rxd; sees uart_data/done/busy/perr/ferr
// slave : the receiver side of the same signals
interface uart_rx_cfg_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [CNT_W-1:0]  uart_cnt;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              uart_rxd;
  logic [DATA_W-1:0] uart_data;
  logic              uart_done;
  logic              uart_busy;
  logic              uart_perr;
  logic              uart_ferr;
  modport master (
    output uart_cnt, cfg_data_bits, cfg_parity, cfg_stop2, uart_rxd,
    input  uart_data, uart_done, uart_busy, uart_perr, uart_ferr
  );
  modport slave (
    input  uart_cnt, cfg_data_bits, cfg_parity, cfg_stop2, uart_rxd,
    output uart_data, uart_done, uart_busy, uart_perr, uart_ferr
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..DATA_W bits, none/even/odd parity, 1/2 stop, 3-sample vote)
// clk, rst_n (async active-low); bus.slave carries uart_cnt, cfg_*, uart_rxd in and
// uart_data, uart_done, uart_busy, uart_perr, uart_ferr out
module uart_rx_cfg #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  uart_rx_cfg_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [3:0] DW4 = 4'(DATA_W);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rxs, rxs_q, start_det, dec, maj, s0, s1, fin, par_en;
  logic [CNT_W-1:0] cnt, cnt_q, half;
  logic [3:0] nb_q, nb_in, bit_idx, bit_idx_n;
  logic [1:0] par_q;
  logic stop2_q, stop_idx, stop_idx_n, par_acc, par_acc_n, ferr_c, ferr_c_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  assign rxs       = sync_q[SYNC_STAGES-1];
  assign start_det = (state == IDLE) && rxs_q && !rxs;
  assign half      = cnt_q >> 1;
  assign dec       = (state != IDLE) && (cnt == half + CNT_W'(1));
  assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign par_en    = par_q[0] ^ par_q[1];
  assign nb_in     = (bus.cfg_data_bits < 4'd5 || bus.cfg_data_bits > DW4) ? DW4 : bus.cfg_data_bits;
  // Every state acts only at its bit's decision point, so switching state there
  // (rather than at bit end) lands the next decision in the next bit's centre.
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_acc_n  = par_acc;
    ferr_c_n   = ferr_c;
    stop_idx_n = stop_idx;
    fin        = 1'b0;
    if (start_det) begin
      state_n    = START;
      bit_idx_n  = 4'd0;
      par_acc_n  = 1'b0;
      ferr_c_n   = 1'b0;
      stop_idx_n = 1'b0;
    end else if (dec) begin
      case (state)
        START: state_n = maj ? IDLE : DATA;
        DATA: begin
          shreg_n   = {maj, shreg[DATA_W-1:1]};
          par_acc_n = par_acc ^ maj;
          bit_idx_n = bit_idx + 4'd1;
          if (bit_idx == nb_q - 4'd1) state_n = par_en ? PARITY : STOP;
        end
        PARITY: begin
          par_acc_n = par_acc ^ maj;
          state_n   = STOP;
        end
        STOP: begin
          ferr_c_n   = ferr_c | ~maj;
          stop_idx_n = 1'b1;
          if (!stop2_q || stop_idx) begin
            fin     = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '1;
      rxs_q         <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      cnt_q         <= '0;
      nb_q          <= DW4;
      par_q         <= 2'b00;
      stop2_q       <= 1'b0;
      s0            <= 1'b1;
      s1            <= 1'b1;
      bit_idx       <= 4'd0;
      shreg         <= '0;
      par_acc       <= 1'b0;
      ferr_c        <= 1'b0;
      stop_idx      <= 1'b0;
      bus.uart_data <= '0;
      bus.uart_done <= 1'b0;
      bus.uart_busy <= 1'b0;
      bus.uart_perr <= 1'b0;
      bus.uart_ferr <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.uart_rxd};
      rxs_q    <= rxs;
      state    <= state_n;
      cnt      <= (start_det || state == IDLE || cnt == cnt_q - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      par_acc  <= par_acc_n;
      ferr_c   <= ferr_c_n;
      stop_idx <= stop_idx_n;
      if (start_det) begin
        cnt_q   <= bus.uart_cnt;
        nb_q    <= nb_in;
        par_q   <= bus.cfg_parity;
        stop2_q <= bus.cfg_stop2;
      end
      if (cnt == half - CNT_W'(1)) s0 <= rxs;
      if (cnt == half) s1 <= rxs;
      bus.uart_done <= fin;
      bus.uart_busy <= (state_n != IDLE) || fin;
      if (fin) begin
        // Bits arrive LSB first at the top of shreg; shifting down drops unused low slots.
        bus.uart_data <= shreg >> (DW4 - nb_q);
        bus.uart_perr <= par_en & (par_acc ^ par_q[1]);
        bus.uart_ferr <= ferr_c_n;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed table-driven and hand-sequenced checks of uart_rx_cfg
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] cap_data;
  logic cap_perr, cap_ferr;
  uart_rx_cfg_if #(.DATA_W(8), .CNT_W(16)) bus ();
  uart_rx_cfg #(.DATA_W(8), .CNT_W(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.uart_done) begin
      done_cnt = done_cnt + 1;
      cap_data = bus.uart_data;
      cap_perr = bus.uart_perr;
      cap_ferr = bus.uart_ferr;
    end
    if (bus.uart_busy) busy_cnt = busy_cnt + 1;
  end
  typedef struct {
    int cnt; int nb_cfg; int nb_tx; int pmode; bit two;
    logic [7:0] data; logic pbit; logic s1; logic s2;
    logic [7:0] exp_data; logic exp_perr; logic exp_ferr;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n, input logic v);
    repeat (n) @(negedge clk) bus.uart_rxd = v;
  endtask
  task automatic send_frame(input int cnt, input int nb, input int pmode, input bit two,
                            input logic [7:0] data, input logic pbit, input logic s1, input logic s2,
                            input int gbit, input int goff);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(data[i]);
    if (pmode == 1 || pmode == 2) bits.push_back(pbit);
    bits.push_back(s1);
    if (two) bits.push_back(s2);
    for (int i = 0; i < bits.size(); i++)
      for (int c = 0; c < cnt; c++) begin
        @(negedge clk);
        bus.uart_rxd = (i == gbit && c == goff) ? ~bits[i] : bits[i];
      end
  endtask
  task automatic set_cfg(input int cnt, input int nb, input int pmode, input bit two);
    bus.uart_cnt = 16'(cnt);
    bus.cfg_data_bits = 4'(nb);
    bus.cfg_parity = 2'(pmode);
    bus.cfg_stop2 = two;
  endtask
  initial begin
    int d0;
    vecs[0]  = '{100, 8, 8, 0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{100, 7, 7, 1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[2]  = '{100, 7, 7, 1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3]  = '{100, 5, 5, 2, 1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b1};
    vecs[4]  = '{16, 6, 6, 2, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[5]  = '{16, 6, 6, 2, 1'b0, 8'h2A, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};
    vecs[6]  = '{20, 8, 8, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{20, 4, 8, 0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[8]  = '{20, 15, 8, 1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[9]  = '{16, 5, 5, 0, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
    vecs[10] = '{16, 8, 8, 3, 1'b0, 8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};
    bus.uart_rxd = 1'b1;
    set_cfg(100, 8, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_data", bus.uart_data, 8'h00);
    chk("rst_done", bus.uart_done, 1'b0);
    chk("rst_busy", bus.uart_busy, 1'b0);
    chk("rst_perr", bus.uart_perr, 1'b0);
    chk("rst_ferr", bus.uart_ferr, 1'b0);
    rst_n = 1'b1;
    idle(20, 1'b1);
    for (int v = 0; v < 11; v++) begin
      set_cfg(vecs[v].cnt, vecs[v].nb_cfg, vecs[v].pmode, vecs[v].two);
      d0 = done_cnt;
      busy_cnt = 0;
      send_frame(vecs[v].cnt, vecs[v].nb_tx, vecs[v].pmode, vecs[v].two, vecs[v].data,
                 vecs[v].pbit, vecs[v].s1, vecs[v].s2, -1, 0);
      set_cfg(7, 0, 3, 1'b1);
      idle(150, 1'b1);
      chk($sformatf("v%0d_dones", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_data", v), cap_data, vecs[v].exp_data);
      chk($sformatf("v%0d_perr", v), cap_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d_ferr", v), cap_ferr, vecs[v].exp_ferr);
      if (v == 0) chk("v0_busy_len", (busy_cnt >= 930 && busy_cnt <= 970), 1);
    end
    // two stop bits, second low, then the line stays low
    set_cfg(100, 5, 2, 1'b1);
    d0 = done_cnt;
    busy_cnt = 0;
    send_frame(100, 5, 2, 1'b1, 8'h15, 1'b0, 1'b1, 1'b0, -1, 0);
    chk("stop2_dones", done_cnt - d0, 1);
    chk("stop2_busy_len", (busy_cnt >= 830 && busy_cnt <= 870), 1);
    chk("stop2_data", cap_data, 8'h15);
    chk("stop2_ferr", cap_ferr, 1'b1);
    chk("stop2_perr", cap_perr, 1'b0);
    d0 = done_cnt;
    busy_cnt = 0;
    idle(2000, 1'b0);
    chk("low_hold_busy", busy_cnt, 0);
    chk("low_hold_dones", done_cnt - d0, 0);
    idle(200, 1'b1);
    // false start: 30-cycle low glitch
    set_cfg(100, 8, 0, 1'b0);
    d0 = done_cnt;
    busy_cnt = 0;
    idle(30, 1'b0);
    idle(300, 1'b1);
    chk("glitch_busy_seen", (busy_cnt > 0 && busy_cnt < 100), 1);
    chk("glitch_dones", done_cnt - d0, 0);
    chk("glitch_data_held", bus.uart_data, 8'h15);
    chk("glitch_busy_now", bus.uart_busy, 1'b0);
    // single-cycle inverted glitch at the centre sample of data bit 2
    d0 = done_cnt;
    send_frame(100, 8, 0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 3, 50);
    idle(150, 1'b1);
    chk("vote_dones", done_cnt - d0, 1);
    chk("vote_data", cap_data, 8'h3C);
    // reset during DATA of 0xFF
    d0 = done_cnt;
    idle(100, 1'b0);
    idle(300, 1'b1);
    rst_n = 1'b0;
    idle(3, 1'b1);
    chk("mid_rst_data", bus.uart_data, 8'h00);
    chk("mid_rst_busy", bus.uart_busy, 1'b0);
    chk("mid_rst_done", bus.uart_done, 1'b0);
    chk("mid_rst_perr", bus.uart_perr, 1'b0);
    chk("mid_rst_ferr", bus.uart_ferr, 1'b0);
    rst_n = 1'b1;
    idle(600, 1'b1);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send_frame(100, 8, 0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 0);
    idle(150, 1'b1);
    chk("post_rst_dones", done_cnt - d0, 1);
    chk("post_rst_data", cap_data, 8'h5A);
    chk("post_rst_ferr", cap_ferr, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
